// File: rtl/gen_burst_trg_pkg.sv
// Shared types for the burst/trigger pattern generator.
//  gen_burst_st_t  : per-channel FSM state
//  gen_burst_cfg_t : shadow copy of one channel's run configuration. Its fields are
//                    sized for the widest supported CW/RW; narrower channels zero-extend.
package gen_burst_pkg;

   localparam int GB_CW = 32;
   localparam int GB_RW = 16;

   typedef logic [GB_CW-1:0] gb_len_t;
   typedef logic [GB_RW-1:0] gb_rep_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DLY  = 2'd1,
      HGH  = 2'd2,
      LOW  = 2'd3
   } gen_burst_st_t;

   typedef struct packed {
      gb_len_t dly;
      gb_len_t hgh;
      gb_len_t low;
      gb_rep_t rep;
      logic    inf;
   } gen_burst_cfg_t;

endpackage

// File: rtl/gen_burst_trg_ch.sv
// One burst/trigger channel: FSM, length counter, repetition counter and shadow cfg.
// Ports:
//  clk, rstn                  system clock, synchronous active-low reset
//  ctl_rst/ctl_stp/ctl_str    soft reset / stop / start pulses (priority in that order)
//  cfg_dly/hgh/low/rep/inf    run configuration, captured on start
//  trg_o                      registered pulse output (high while in HGH, one cycle later)
//  sts_run/sts_end/sts_rep    busy, natural-completion pulse, completed periods
//
// state | meaning
// IDLE  | waiting for start
// DLY   | start delay, cfg_dly cycles
// HGH   | pulse high phase, hgh+1 cycles
// LOW   | pulse low phase, low+1 cycles; period boundary on exit
module gen_burst_trg_ch
   import gen_burst_pkg::*;
#(
   parameter int CW = 32,
   parameter int RW = 16
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          ctl_rst,
   input  logic          ctl_stp,
   input  logic          ctl_str,
   input  logic [CW-1:0] cfg_dly,
   input  logic [CW-1:0] cfg_hgh,
   input  logic [CW-1:0] cfg_low,
   input  logic [RW-1:0] cfg_rep,
   input  logic          cfg_inf,
   output logic          trg_o,
   output logic          sts_run,
   output logic          sts_end,
   output logic [RW-1:0] sts_rep
);

   gen_burst_st_t  state_q, state_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
   logic [RW-1:0]  rep_q,   rep_d;
   gen_burst_cfg_t shd_q,   shd_d;
   logic           trg_q,   trg_d;
   logic           end_q,   end_d;

   gb_len_t cnt_x;
   logic    last_per;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rep_d    = rep_q;
      shd_d    = shd_q;
      end_d    = 1'b0;
      // trg_o lags the state by one cycle so start latency is n+1+D
      trg_d    = (state_q == HGH);
      cnt_x    = gb_len_t'(cnt_q);
      last_per = !shd_q.inf && (gb_rep_t'(rep_q) == shd_q.rep);

      if (ctl_rst) begin
         state_d = IDLE;
         cnt_d   = '0;
         rep_d   = '0;
         shd_d   = '0;
         trg_d   = 1'b0;
      end else if (ctl_stp) begin
         state_d = IDLE;
         cnt_d   = '0;
         trg_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ctl_str) begin
                  shd_d.dly = gb_len_t'(cfg_dly);
                  shd_d.hgh = gb_len_t'(cfg_hgh);
                  shd_d.low = gb_len_t'(cfg_low);
                  shd_d.rep = gb_rep_t'(cfg_rep);
                  shd_d.inf = cfg_inf;
                  rep_d     = '0;
                  cnt_d     = '0;
                  state_d   = (cfg_dly != '0) ? DLY : HGH;
               end
            end
            DLY: begin
               if (cnt_x == shd_q.dly - gb_len_t'(1)) begin
                  state_d = HGH;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            HGH: begin
               if (cnt_x == shd_q.hgh) begin
                  state_d = LOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            LOW: begin
               if (cnt_x == shd_q.low) begin
                  cnt_d = '0;
                  rep_d = rep_q + 1'b1;
                  if (last_per) begin
                     state_d = IDLE;
                     end_d   = 1'b1;
                  end else begin
                     state_d = HGH;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rep_q   <= '0;
         shd_q   <= '0;
         trg_q   <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rep_q   <= rep_d;
         shd_q   <= shd_d;
         trg_q   <= trg_d;
         end_q   <= end_d;
      end
   end

   assign trg_o   = trg_q;
   assign sts_run = (state_q != IDLE);
   assign sts_end = end_q;
   assign sts_rep = rep_q;

endmodule

// File: rtl/gen_burst_trg.sv
// Multi-channel burst/trigger pattern generator: CN independent gen_burst_trg_ch channels.
// Ports:
//  clk, rstn            system clock, synchronous active-low reset
//  ctl_rst/stp/str[CN]  per-channel soft reset / stop / start pulses
//  cfg_*                per-channel configuration, channel i at [i*W +: W]
//  trg_o/sts_*          per-channel pulse train and status
// Build option GEN_BURST_TRG_EXT_EN adds trg_i (external trigger) and cfg_ext[CN]; a rising
// edge of trg_i, detected through registers (one extra cycle), starts every channel whose
// cfg_ext bit is set, exactly like ctl_str.
module gen_burst_trg
   import gen_burst_pkg::*;
#(
   parameter int CN = 2,
   parameter int CW = 32,
   parameter int RW = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [CN-1:0]    ctl_rst,
   input  logic [CN-1:0]    ctl_str,
   input  logic [CN-1:0]    ctl_stp,
   input  logic [CN*CW-1:0] cfg_dly,
   input  logic [CN*CW-1:0] cfg_hgh,
   input  logic [CN*CW-1:0] cfg_low,
   input  logic [CN*RW-1:0] cfg_rep,
   input  logic [CN-1:0]    cfg_inf,
`ifdef GEN_BURST_TRG_EXT_EN
   input  logic             trg_i,
   input  logic [CN-1:0]    cfg_ext,
`endif
   output logic [CN-1:0]    trg_o,
   output logic [CN-1:0]    sts_run,
   output logic [CN-1:0]    sts_end,
   output logic [CN*RW-1:0] sts_rep
);

   logic [CN-1:0] str_eff;

`ifdef GEN_BURST_TRG_EXT_EN
   logic trg_i_q, trg_i_d;
   logic rise_q,  rise_d;

   always_comb begin
      trg_i_d = trg_i;
      rise_d  = trg_i & ~trg_i_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         trg_i_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         trg_i_q <= trg_i_d;
         rise_q  <= rise_d;
      end
   end

   assign str_eff = ctl_str | ({CN{rise_q}} & cfg_ext);
`else
   assign str_eff = ctl_str;
`endif

   for (genvar i = 0; i < CN; i++) begin : g_ch
      gen_burst_trg_ch #(
         .CW (CW),
         .RW (RW)
      ) u_ch (
         .clk     (clk),
         .rstn    (rstn),
         .ctl_rst (ctl_rst[i]),
         .ctl_stp (ctl_stp[i]),
         .ctl_str (str_eff[i]),
         .cfg_dly (cfg_dly[i*CW +: CW]),
         .cfg_hgh (cfg_hgh[i*CW +: CW]),
         .cfg_low (cfg_low[i*CW +: CW]),
         .cfg_rep (cfg_rep[i*RW +: RW]),
         .cfg_inf (cfg_inf[i]),
         .trg_o   (trg_o[i]),
         .sts_run (sts_run[i]),
         .sts_end (sts_end[i]),
         .sts_rep (sts_rep[i*RW +: RW])
      );
   end

endmodule

// File: tb/tb_gen_burst_trg.sv
module tb_gen_burst_trg;

   localparam int CN = 2;
   localparam int CW = 32;
   localparam int RW = 8;

   logic             clk = 1'b0;
   logic             rstn;
   logic [CN-1:0]    ctl_rst, ctl_str, ctl_stp, cfg_inf;
   logic [CN*CW-1:0] cfg_dly, cfg_hgh, cfg_low;
   logic [CN*RW-1:0] cfg_rep;
`ifdef GEN_BURST_TRG_EXT_EN
   logic             trg_i;
   logic [CN-1:0]    cfg_ext;
`endif
   logic [CN-1:0]    trg_o, sts_run, sts_end;
   logic [CN*RW-1:0] sts_rep;

   int total = 0;
   int bad   = 0;
   logic [CN-1:0] sb_q[$];

   always #5 clk = ~clk;

   gen_burst_trg #(.CN(CN), .CW(CW), .RW(RW)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .ctl_rst (ctl_rst),
      .ctl_str (ctl_str),
      .ctl_stp (ctl_stp),
      .cfg_dly (cfg_dly),
      .cfg_hgh (cfg_hgh),
      .cfg_low (cfg_low),
      .cfg_rep (cfg_rep),
      .cfg_inf (cfg_inf),
`ifdef GEN_BURST_TRG_EXT_EN
      .trg_i   (trg_i),
      .cfg_ext (cfg_ext),
`endif
      .trg_o   (trg_o),
      .sts_run (sts_run),
      .sts_end (sts_end),
      .sts_rep (sts_rep)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // one clock; outputs sampled 1 time unit after the edge, scoreboard popped per cycle
   task automatic step();
      logic [CN-1:0] e;
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("trg_o_sb", 32'(trg_o), 32'(e));
      end
   endtask

   task automatic set_ch(input int c, input logic [CW-1:0] d, input logic [CW-1:0] h,
                         input logic [CW-1:0] l, input logic [RW-1:0] r, input logic inf);
      cfg_dly[c*CW +: CW] = d;
      cfg_hgh[c*CW +: CW] = h;
      cfg_low[c*CW +: CW] = l;
      cfg_rep[c*RW +: RW] = r;
      cfg_inf[c]          = inf;
   endtask

   initial begin
      rstn = 1'b0;
      ctl_rst = '0; ctl_str = '0; ctl_stp = '0;
      cfg_dly = '0; cfg_hgh = '0; cfg_low = '0; cfg_rep = '0; cfg_inf = '0;
`ifdef GEN_BURST_TRG_EXT_EN
      trg_i = 1'b0;
      cfg_ext = '0;
`endif
      step();
      step();
      chk("rst_trg", 32'(trg_o), 32'd0);
      chk("rst_run", 32'(sts_run), 32'd0);
      chk("rst_end", 32'(sts_end), 32'd0);
      chk("rst_rep", 32'(sts_rep), 32'd0);
      rstn = 1'b1;
      step();

      // finite burst on ch0, mid-run cfg change and start retrigger must be ignored
      set_ch(0, 32'd0, 32'd3, 32'd5, 8'd2, 1'b0);
      for (int k = 0; k <= 30; k++)
         sb_q.push_back({1'b0, (k >= 1 && k <= 30 && ((k - 1) % 10) < 4)});
      ctl_str = 2'b01;
      for (int k = 0; k <= 30; k++) begin
         step();
         ctl_str = (k == 12) ? 2'b01 : 2'b00;
         if (k == 5) cfg_hgh[0 +: CW] = 32'd7;
         if (k == 9)  chk("fin_rep_k9",  32'(sts_rep[0 +: RW]), 32'd0);
         if (k == 10) chk("fin_rep_k10", 32'(sts_rep[0 +: RW]), 32'd1);
         if (k == 29) begin
            chk("fin_run_k29", 32'(sts_run[0]), 32'd1);
            chk("fin_end_k29", 32'(sts_end[0]), 32'd0);
            chk("fin_rep_k29", 32'(sts_rep[0 +: RW]), 32'd2);
         end
         if (k == 30) begin
            chk("fin_end_k30", 32'(sts_end[0]), 32'd1);
            chk("fin_run_k30", 32'(sts_run[0]), 32'd0);
            chk("fin_rep_k30", 32'(sts_rep[0 +: RW]), 32'd3);
         end
      end
      step();
      chk("fin_end_one", 32'(sts_end[0]), 32'd0);
      cfg_hgh[0 +: CW] = 32'd3;

      // infinite toggling on ch1 with delay, wrap of sts_rep, stop in HGH
      set_ch(1, 32'd10, 32'd0, 32'd0, 8'd0, 1'b1);
      for (int k = 0; k <= 531; k++)
         sb_q.push_back({(k >= 11 && k <= 530 && ((k - 11) % 2) == 0), 1'b0});
      ctl_str = 2'b10;
      for (int k = 0; k <= 531; k++) begin
         step();
         ctl_str = 2'b00;
         ctl_stp = (k == 530) ? 2'b10 : 2'b00;
         if (k == 10)  chk("inf_run_dly", 32'(sts_run[1]), 32'd1);
         if (k == 100) chk("inf_ch0_rep", 32'(sts_rep[0 +: RW]), 32'd3);
         if (k == 520) chk("inf_rep_255", 32'(sts_rep[RW +: RW]), 32'd255);
         if (k == 522) chk("inf_rep_wrap", 32'(sts_rep[RW +: RW]), 32'd0);
         if (k == 524) chk("inf_rep_1", 32'(sts_rep[RW +: RW]), 32'd1);
         if (k == 531) begin
            chk("stp_run", 32'(sts_run[1]), 32'd0);
            chk("stp_end", 32'(sts_end[1]), 32'd0);
            chk("stp_rep", 32'(sts_rep[RW +: RW]), 32'd4);
         end
      end
      ctl_stp = 2'b00;
      step();
      chk("stp_trg_hold", 32'(trg_o), 32'd0);
      chk("stp_rep_hold", 32'(sts_rep[RW +: RW]), 32'd4);
      ctl_rst = 2'b10;
      step();
      ctl_rst = 2'b00;
      chk("crst_rep", 32'(sts_rep[RW +: RW]), 32'd0);
      chk("crst_ch0_rep", 32'(sts_rep[0 +: RW]), 32'd3);

      // stop and start together in IDLE: no start, sts_rep untouched
      ctl_stp = 2'b01;
      ctl_str = 2'b01;
      step();
      ctl_stp = 2'b00;
      ctl_str = 2'b00;
      chk("stpstr_run", 32'(sts_run[0]), 32'd0);
      chk("stpstr_rep", 32'(sts_rep[0 +: RW]), 32'd3);
      step();
      chk("stpstr_trg", 32'(trg_o), 32'd0);

      // global reset while both channels run
      set_ch(1, 32'd0, 32'd3, 32'd5, 8'd2, 1'b0);
      ctl_str = 2'b11;
      step();
      ctl_str = 2'b00;
      step();
      chk("both_trg", 32'(trg_o), 32'd3);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("grst_trg", 32'(trg_o), 32'd0);
      chk("grst_run", 32'(sts_run), 32'd0);
      chk("grst_end", 32'(sts_end), 32'd0);
      chk("grst_rep", 32'(sts_rep), 32'd0);
      step();
      chk("grst_trg_after", 32'(trg_o), 32'd0);

`ifdef GEN_BURST_TRG_EXT_EN
      cfg_ext = 2'b10;
      trg_i = 1'b1;
      step();
      step();
      chk("ext_trg_m1", 32'(trg_o), 32'd0);
      step();
      chk("ext_trg_m2", 32'(trg_o), 32'd2);
      chk("ext_run", 32'(sts_run), 32'd2);
      trg_i = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
